// File: rtl/datamem_scan_pkg.sv
// rtl/datamem_scan_pkg.sv - shared state encoding and default sizes for the data-memory scan reader
package datamem_scan_pkg;

    localparam int SCAN_WORDS  = 64;
    localparam int SCAN_ADDR_W = 12;
    localparam int SCAN_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SWAP = 2'd2
    } scan_state_t;

endpackage

// File: rtl/snapshot_bank.sv
// rtl/snapshot_bank.sv - double-buffered snapshot storage: write port on the back bank, registered read on the front bank
module snapshot_bank
    import datamem_scan_pkg::*;
#(
    parameter int WORDS  = SCAN_WORDS,
    parameter int DATA_W = SCAN_DATA_W,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bank_sel,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] banks [2][WORDS];

    // bank_sel names the front bank; writes always land in the other one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < WORDS; w++) begin
                    banks[b][w] <= '0;
                end
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                banks[~bank_sel][wr_index] <= wr_data;
            end
            rd_data <= banks[bank_sel][rd_index];
        end
    end

endmodule

// File: rtl/datamem_scan_reader.sv
// rtl/datamem_scan_reader.sv - per-frame data-memory scanner feeding a tear-free snapshot for the renderer
// Optional running checksum output enabled by DATAMEM_SCAN_CHECKSUM_EN.
module datamem_scan_reader
    import datamem_scan_pkg::*;
#(
    parameter int WORDS     = SCAN_WORDS,
    parameter int ADDR_W    = SCAN_ADDR_W,
    parameter int DATA_W    = SCAN_DATA_W,
    parameter int BASE_ADDR = 0,
    localparam int IDX_W    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpu_mem_busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [IDX_W-1:0]  disp_index,
    output logic [DATA_W-1:0] disp_word,
    output logic              busy,
    output logic              done,
    output logic              snapshot_valid
`ifdef DATAMEM_SCAN_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [IDX_W-1:0]  LAST_INDEX = IDX_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [IDX_W-1:0] index;
    logic             bank_sel;
    logic             granted;
    logic             last_grant;

    // The CPU always wins the read port; the scan only advances on cycles it leaves free
    assign granted    = (state == SCAN) && !cpu_mem_busy;
    assign last_grant = granted && (index == LAST_INDEX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last_grant) state_next = SWAP;
            SWAP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_read_enable = granted;
        mem_address     = BASE;
        busy            = 1'b0;
        done            = 1'b0;
        if (state == SCAN) begin
            mem_address = BASE + ADDR_W'(index);
            busy        = 1'b1;
        end
        if (state == SWAP) begin
            done = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index          <= '0;
            bank_sel       <= 1'b0;
            snapshot_valid <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                index <= '0;
            end else if (granted) begin
                index <= index + 1'b1;
            end
            if (state == SWAP) begin
                bank_sel       <= ~bank_sel;
                snapshot_valid <= 1'b1;
            end
        end
    end

`ifdef DATAMEM_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_acc <= '0;
            checksum     <= '0;
        end else begin
            if (state == IDLE && start) begin
                checksum_acc <= '0;
            end else if (granted) begin
                checksum_acc <= checksum_acc + mem_read_data;
            end
            if (state == SWAP) begin
                checksum <= checksum_acc;
            end
        end
    end
`endif

    snapshot_bank #(
        .WORDS  (WORDS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_snapshot_bank (
        .clk      (clk),
        .rst      (rst),
        .bank_sel (bank_sel),
        .wr_en    (granted),
        .wr_index (index),
        .wr_data  (mem_read_data),
        .rd_index (disp_index),
        .rd_data  (disp_word)
    );

endmodule

// File: tb/tb_datamem_scan_reader.sv
// tb/tb_datamem_scan_reader.sv - randomized self-checking bench for datamem_scan_reader
module tb_datamem_scan_reader;

    localparam int WORDS  = 64;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int BASE   = 12'hFE0;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              cpu_mem_busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_read_data;
    logic [5:0]        disp_index;
    logic [DATA_W-1:0] disp_word;
    logic              busy;
    logic              done;
    logic              snapshot_valid;
`ifdef DATAMEM_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    logic [DATA_W-1:0] mem [4096];
    logic [DATA_W-1:0] expected_front [WORDS];
    int errors = 0;
    int checks = 0;

    assign mem_read_data = mem[mem_address];

    always #5 clk = ~clk;

    datamem_scan_reader #(
        .WORDS     (WORDS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cpu_mem_busy    (cpu_mem_busy),
        .mem_address     (mem_address),
        .mem_read_enable (mem_read_enable),
        .mem_read_data   (mem_read_data),
        .disp_index      (disp_index),
        .disp_word       (disp_word),
        .busy            (busy),
        .done            (done),
        .snapshot_valid  (snapshot_valid)
`ifdef DATAMEM_SCAN_CHECKSUM_EN
        ,
        .checksum        (checksum)
`endif
    );

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return ADDR_W'((BASE + i) % 4096);
    endfunction

    // mode 0: A000+i, 1: random, 2: i+1, 3: all FFFF, other: constant value
    task automatic fill_mem(input int mode, input logic [DATA_W-1:0] value);
        for (int i = 0; i < WORDS; i++) begin
            case (mode)
                0:       mem[addr_of(i)] = 16'hA000 + 16'(i);
                1:       mem[addr_of(i)] = 16'($urandom);
                2:       mem[addr_of(i)] = 16'(i + 1);
                3:       mem[addr_of(i)] = 16'hFFFF;
                default: mem[addr_of(i)] = value;
            endcase
        end
    endtask

    task automatic read_word(input int idx, output logic [DATA_W-1:0] val);
        @(posedge clk); #1 disp_index = 6'(idx);
        @(posedge clk); #1 val = disp_word;
    endtask

    task automatic check_front(input string tag);
        logic [DATA_W-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            read_word(i, v);
            checks++;
            if (v !== expected_front[i]) begin
                errors++;
                $display("FAIL %s word %0d: got %h expected %h", tag, i, v, expected_front[i]);
            end
        end
    endtask

    // One full scan: bench decides stalls, predicts address/grant/done timing and the resulting snapshot
    task automatic run_scan(input string tag, input int rand_pct, input int stall_at, input int stall_len,
                            input bit extra_starts, input bit watch_disp,
                            input logic [DATA_W-1:0] old_word, input logic [DATA_W-1:0] new_word);
        logic [DATA_W-1:0] snap [WORDS];
        logic [DATA_W-1:0] sum = '0;
        int grants = 0, stalls = 0, held = 0, swap_cycle = 0;
        bit cpu, hit30 = 0, finished = 0;
        for (int i = 0; i < WORDS; i++) begin
            snap[i] = mem[addr_of(i)];
            sum += snap[i];
        end
        @(posedge clk); #1 start = 1'b1; cpu_mem_busy = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 1; n <= 2000 && !finished; n++) begin
            if (grants < WORDS) begin
                cpu = 1'b0;
                if (grants == stall_at && held < stall_len) begin
                    cpu = 1'b1;
                    held++;
                end else if (rand_pct > 0 && $urandom_range(99) < rand_pct) begin
                    cpu = 1'b1;
                end
                cpu_mem_busy = cpu;
                start = extra_starts && ((grants == 30 && !hit30) || (grants == WORDS - 1 && !cpu));
                if (grants == 30) hit30 = 1'b1;
            end else begin
                cpu_mem_busy = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            if (watch_disp) begin
                checks++;
                if (disp_word !== old_word) begin
                    errors++;
                    $display("FAIL %s disp during scan cycle %0d: got %h expected %h", tag, n, disp_word, old_word);
                end
            end
            if (grants < WORDS) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || mem_read_enable !== !cpu ||
                    mem_address !== addr_of(grants)) begin
                    errors++;
                    $display("FAIL %s scan cycle %0d: busy=%b done=%b re=%b addr=%h expected busy=1 done=0 re=%b addr=%h",
                             tag, n, busy, done, mem_read_enable, mem_address, !cpu, addr_of(grants));
                end
                if (!cpu) grants++;
                else stalls++;
            end else begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || mem_read_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL %s swap cycle: done=%b busy=%b re=%b expected 1 0 0", tag, done, busy, mem_read_enable);
                end
                swap_cycle = n;
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: no swap within 2000 cycles, got %0d grants expected %0d", tag, grants, WORDS);
        end else if (swap_cycle != WORDS + 1 + stalls) begin
            errors++;
            $display("FAIL %s done latency: got %0d expected %0d", tag, swap_cycle, WORDS + 1 + stalls);
        end
        @(posedge clk); #1 start = 1'b0; cpu_mem_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || snapshot_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s after swap: done=%b busy=%b valid=%b expected 0 0 1", tag, done, busy, snapshot_valid);
        end
`ifdef DATAMEM_SCAN_CHECKSUM_EN
        checks++;
        if (checksum !== sum) begin
            errors++;
            $display("FAIL %s checksum: got %h expected %h", tag, checksum, sum);
        end
`endif
        if (watch_disp) begin
            checks++;
            if (disp_word !== old_word) begin
                errors++;
                $display("FAIL %s disp on swap edge: got %h expected %h", tag, disp_word, old_word);
            end
            @(negedge clk);
            checks++;
            if (disp_word !== new_word) begin
                errors++;
                $display("FAIL %s disp after swap: got %h expected %h", tag, disp_word, new_word);
            end
        end
        // dropped start pulses must not restart the scan
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s idle after scan: busy=%b done=%b expected 0 0", tag, busy, done);
            end
        end
        for (int i = 0; i < WORDS; i++) expected_front[i] = snap[i];
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cpu_mem_busy = 1'b0; disp_index = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || snapshot_valid !== 1'b0 || disp_word !== 16'h0 ||
            mem_read_enable !== 1'b0 || mem_address !== ADDR_W'(BASE)) begin
            errors++;
            $display("FAIL reset outputs: busy=%b done=%b valid=%b disp=%h re=%b addr=%h expected 0 0 0 0000 0 %h",
                     busy, done, snapshot_valid, disp_word, mem_read_enable, mem_address, ADDR_W'(BASE));
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < WORDS; i++) expected_front[i] = '0;
        check_front("reset_banks");
    endtask

    task automatic test_full_scan;
        fill_mem(0, '0);
        run_scan("full_scan", 0, -1, 0, 1'b0, 1'b0, '0, '0);
        check_front("full_scan");
    endtask

    task automatic test_stall;
        fill_mem(0, '0);
        run_scan("stall", 0, 20, 10, 1'b0, 1'b0, '0, '0);
        check_front("stall");
    endtask

    task automatic test_no_tearing;
        fill_mem(4, 16'h1111);
        run_scan("tear_prep", 0, -1, 0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1 disp_index = 6'd7;
        fill_mem(4, 16'h2222);
        @(posedge clk);
        run_scan("tear", 20, -1, 0, 1'b0, 1'b1, 16'h1111, 16'h2222);
    endtask

    task automatic test_back_to_back_start;
        fill_mem(1, '0);
        run_scan("extra_start", 0, -1, 0, 1'b1, 1'b0, '0, '0);
        check_front("extra_start");
    endtask

    task automatic test_random_stalls;
        for (int k = 0; k < 3; k++) begin
            fill_mem(1, '0);
            run_scan("random", 35, $urandom_range(63), $urandom_range(8), 1'b0, 1'b0, '0, '0);
            check_front("random");
        end
    endtask

    task automatic test_reset_mid_scan;
        int done_seen = 0;
        fill_mem(1, '0);
        @(posedge clk); #1 start = 1'b1; cpu_mem_busy = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (mem_address !== addr_of(40) || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan position: addr=%h busy=%b expected %h 1", mem_address, busy, addr_of(40));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || snapshot_valid !== 1'b0 || disp_word !== 16'h0 || done !== 1'b0 ||
            mem_read_enable !== 1'b0 || mem_address !== ADDR_W'(BASE)) begin
            errors++;
            $display("FAIL mid_scan reset: busy=%b valid=%b disp=%h done=%b re=%b addr=%h expected 0 0 0000 0 0 %h",
                     busy, snapshot_valid, disp_word, done, mem_read_enable, mem_address, ADDR_W'(BASE));
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL mid_scan aborted: got %0d active cycles expected 0", done_seen);
        end
        for (int i = 0; i < WORDS; i++) expected_front[i] = '0;
        check_front("mid_scan_cleared");
        run_scan("after_reset", 0, -1, 0, 1'b0, 1'b0, '0, '0);
        check_front("after_reset");
    endtask

`ifdef DATAMEM_SCAN_CHECKSUM_EN
    task automatic test_checksum;
        fill_mem(2, '0);
        run_scan("cksum_ramp", 25, -1, 0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (checksum !== 16'd2080) begin
            errors++;
            $display("FAIL checksum ramp: got %h expected %h", checksum, 16'd2080);
        end
        fill_mem(3, '0);
        run_scan("cksum_wrap", 0, -1, 0, 1'b0, 1'b0, '0, '0);
        checks++;
        if (checksum !== 16'hFFC0) begin
            errors++;
            $display("FAIL checksum wrap: got %h expected %h", checksum, 16'hFFC0);
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 16'(a * 7 + 3);
        test_reset();
        test_full_scan();
        test_stall();
        test_no_tearing();
        test_back_to_back_start();
        test_random_stalls();
        test_reset_mid_scan();
`ifdef DATAMEM_SCAN_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
